// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// traps illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
    parameter int ALUOP_W  = 2,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               PCSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        C_LOAD,
        C_STORE,
        C_RTYPE,
        C_IALU,
        C_BRANCH,
        C_BAD
    } cls_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    cls_e               cls;
    logic               rdy;
    logic               retire;

    assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    always_comb begin
        cls = C_BAD;
        if (opcode[1:0] == 2'b11 && opcode[3:2] == 2'b00) begin
            case (opcode[6:4])
                3'b000:  cls = C_LOAD;
                3'b010:  cls = C_STORE;
                3'b011:  cls = C_RTYPE;
                3'b001:  cls = C_IALU;
                3'b110:  cls = C_BRANCH;
                default: cls = C_BAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_LOAD, C_STORE: state_d = S_MEMADR;
                    C_RTYPE:         state_d = S_EXEC_R;
                    C_IALU:          state_d = S_EXEC_I;
                    C_BRANCH:        state_d = S_BRANCH;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                case (cls)
                    C_LOAD:  state_d = S_MEMRD;
                    C_STORE: state_d = S_MEMWR;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMRD: if (rdy) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (rdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    logic [1:0] aluop2;

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        PCSrc    = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        aluop2   = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                aluop2  = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                aluop2  = 2'b11;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                aluop2  = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = zero;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
        // Asserting reset silences every enable at once, not at the next edge
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemToReg = 1'b0;
            RegWrite = 1'b0;
            PCSrc    = 1'b0;
            ALUSrcA  = 2'b00;
            ALUSrcB  = 2'b00;
            aluop2   = 2'b00;
            illegal  = 1'b0;
        end
        ALUOp = ALUOP_W'(aluop2);
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: per-instruction cycle scripts expanded from
// the opcode class and chosen memory waits, compared every cycle.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic       MemToReg, RegWrite, PCSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal;
    logic [3:0] retired;

    multicycle_control_unit #(
        .ALUOP_W (2),
        .MEM_WAIT(1),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .zero     (zero),
        .mem_ready(mem_ready),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemToReg (MemToReg),
        .RegWrite (RegWrite),
        .PCSrc    (PCSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .state    (state),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, iord, mrd, mwr, m2r, rw, pcsrc;
        logic [1:0] sa, sb, aop;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic [6:0] op;
        exp_t       e;
        logic       ret;
    } cyc_t;

    cyc_t q[$];
    exp_t alog[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt = 0;
    bit   trapped = 0;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    function automatic exp_t act_now();
        return {state, PCWrite, IRWrite, IorD, MemRead, MemWrite,
                MemToReg, RegWrite, PCSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};
    endfunction

    // Output table from the state names of the control-flow description
    function automatic exp_t outs(int st, logic mr, logic z);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0: begin e.mrd = 1; e.sb = 2'b01; e.irw = mr; e.pcw = mr; end
            1: begin e.sa = 2'b01; e.sb = 2'b10; end
            2: begin e.sa = 2'b10; e.sb = 2'b10; end
            3: begin e.iord = 1; e.mrd = 1; end
            4: begin e.rw = 1; e.m2r = 1; end
            5: begin e.iord = 1; e.mwr = 1; end
            6: begin e.sa = 2'b10; e.sb = 2'b00; e.aop = 2'b10; end
            7: begin e.sa = 2'b10; e.sb = 2'b10; e.aop = 2'b11; end
            8: e.rw = 1;
            9: begin e.sa = 2'b10; e.aop = 2'b01; e.pcsrc = 1; e.pcw = z; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        if (op[1:0] != 2'b11 || op[3:2] != 2'b00) return 0;
        return op[6:4] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
    endfunction

    function automatic logic [6:0] rand_legal();
        logic [6:0] t[5];
        t = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR};
        return t[$urandom_range(4)];
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] op;
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
        return op;
    endfunction

    task automatic push(int st, logic mr, logic z, logic [6:0] op, logic ret);
        cyc_t c;
        c.mr = mr;
        c.z = z;
        c.op = op;
        c.e = outs(st, mr, z);
        c.ret = ret;
        q.push_back(c);
    endtask

    task automatic push_mem(int st, int waits, logic [6:0] op, logic ret);
        for (int i = 0; i < waits; i++) push(st, 1'b0, rb(), op, 1'b0);
        push(st, 1'b1, rb(), op, ret);
    endtask

    // Expand one instruction into its expected cycle script
    task automatic push_instr(logic [6:0] op, logic z, int fw, int mw);
        push_mem(0, fw, 7'($urandom), 1'b0);
        push(1, rb(), rb(), op, 1'b0);
        if (!is_legal(op)) begin
            trapped = 1;
            for (int i = 0; i < 20; i++) push(10, rb(), rb(), rand_legal(), 1'b0);
        end else begin
            case (op[6:4])
                3'b000: begin
                    push(2, rb(), rb(), op, 1'b0);
                    push_mem(3, mw, op, 1'b0);
                    push(4, rb(), rb(), op, 1'b1);
                end
                3'b010: begin
                    push(2, rb(), rb(), op, 1'b0);
                    push_mem(5, mw, op, 1'b1);
                end
                3'b011: begin
                    push(6, rb(), rb(), op, 1'b0);
                    push(8, rb(), rb(), op, 1'b1);
                end
                3'b001: begin
                    push(7, rb(), rb(), op, 1'b0);
                    push(8, rb(), rb(), op, 1'b1);
                end
                default: push(9, rb(), z, op, 1'b1);
            endcase
        end
    endtask

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_outs", 32'(act_now()), 32'(exp_t'('0)));
        chk("reset_retired", 32'(retired), 32'd0);
        q.delete();
        alog.delete();
        cnt = 0;
        trapped = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(int n, bit settle);
        cyc_t c;
        exp_t a;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            @(negedge clk);
            mem_ready = c.mr;
            zero = c.z;
            opcode = c.op;
            #1;
            a = act_now();
            alog.push_back(a);
            chk("cycle_outs", 32'(a), 32'(c.e));
            chk("cycle_retired", 32'(retired), 32'(cnt % 16));
            if (c.ret) cnt++;
        end
        if (settle) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            chk("settle_outs", 32'(act_now()), 32'(outs(trapped ? 10 : 0, 1'b0, 1'b0)));
            chk("settle_retired", 32'(retired), 32'(cnt % 16));
        end
    endtask

    initial begin
        int lseq[$];

        // R-type: 0,1,6,8 then back to fetch
        do_reset();
        push_instr(OP_R, 1'b0, 0, 0);
        run(q.size(), 1);
        lseq = '{0, 1, 6, 8};
        chk("r_len", 32'(alog.size()), 32'(lseq.size()));
        foreach (lseq[i]) if (i < alog.size()) chk("r_seq", 32'(alog[i].st), 32'(lseq[i]));
        if (alog.size() > 3) begin
            chk("r_aluop", 32'(alog[2].aop), 32'd2);
            chk("r_regwrite", 32'({alog[0].rw, alog[1].rw, alog[2].rw, alog[3].rw}), 32'b0001);
        end
        chk("r_retired", 32'(retired), 32'd1);

        // Load with two MEMRD waits
        do_reset();
        push_instr(OP_LD, 1'b0, 0, 2);
        run(q.size(), 1);
        lseq = '{0, 1, 2, 3, 3, 3, 4};
        chk("ld_len", 32'(alog.size()), 32'(lseq.size()));
        foreach (lseq[i]) if (i < alog.size()) chk("ld_seq", 32'(alog[i].st), 32'(lseq[i]));
        if (alog.size() > 6) begin
            chk("ld_memrd", 32'({alog[3].mrd, alog[4].iord, alog[5].mrd}), 32'b111);
            chk("ld_wb", 32'({alog[6].m2r, alog[6].rw}), 32'b11);
        end
        chk("ld_retired", 32'(retired), 32'd1);

        // Branch taken then not taken
        do_reset();
        push_instr(OP_BR, 1'b1, 0, 0);
        push_instr(OP_BR, 1'b0, 1, 0);
        run(q.size(), 1);
        if (alog.size() > 6) begin
            chk("br_taken", 32'({alog[2].st, alog[2].pcw, alog[2].pcsrc}), {26'd0, 4'd9, 2'b11});
            chk("br_nottaken", 32'({alog[6].st, alog[6].pcw, alog[6].pcsrc}), {26'd0, 4'd9, 2'b01});
        end
        chk("br_retired", 32'(retired), 32'd2);

        // Illegal opcode traps and stays trapped under legal opcodes
        do_reset();
        push_instr(7'h7F, 1'b0, 0, 0);
        run(q.size(), 1);
        if (alog.size() > 2) chk("trap_state", 32'({alog[2].st, alog[2].ill}), 32'h15);
        chk("trap_hold", 32'(illegal), 32'd1);

        // Reset pulsed while a store sits in MEMWR
        do_reset();
        for (int i = 0; i < 3; i++) push_instr(OP_I, 1'b0, $urandom_range(1), 0);
        push_instr(OP_ST, 1'b0, 0, 5);
        run(q.size() - 4, 0);
        chk("st_memwr", 32'({state, MemWrite}), 32'({4'd5, 1'b1}));
        #2;
        reset = 1'b0;
        #1;
        chk("st_abort", 32'({state, MemWrite, RegWrite, PCWrite}), 32'd0);
        chk("st_abort_ret", 32'(retired), 32'd0);
        q.delete();
        cnt = 0;
        @(negedge clk);
        reset = 1'b1;

        // 17 I-ALU retirements wrap a 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) push_instr(OP_I, rb(), $urandom_range(2), 0);
        run(q.size(), 1);
        chk("wrap_retired", 32'(retired), 32'd1);

        // Random instruction streams with random memory stalls
        for (int b = 0; b < 6; b++) begin
            do_reset();
            for (int i = 0; i < 40 && !trapped; i++) begin
                if ($urandom_range(19) == 0)
                    push_instr(rand_illegal(), rb(), $urandom_range(3), 0);
                else
                    push_instr(rand_legal(), rb(), $urandom_range(3), $urandom_range(3));
            end
            run(q.size(), 1);
        end

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control unit for the RV32I datapath. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. Memory accesses are stretched by a `mem_ready` handshake. Illegal opcodes are trapped, and the unit keeps a count of retired instructions. It sits between the instruction register / `zero` flag and the shared-memory datapath muxes and enables.

## Interface
- `ALUOP_W`, default 2: ALUOp width, must be ≥2. Bits above [1:0] are always 0.
- `MEM_WAIT`, default 1: 1 = honour `mem_ready`; 0 = every memory state completes in one cycle and `mem_ready` is ignored.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 7: instruction[6:0] from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, PCSrc` out 1: datapath enables and selects.
- `ALUSrcA` out 2: 00 = PC, 01 = oldPC, 10 = rs1.
- `ALUSrcB` out 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` out `ALUOP_W`: 00 = add, 01 = subtract/compare, 10 = R-type funct, 11 = I-type funct.
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: trap indicator, sticky until reset.
- `retired` out `CNT_W`: retired-instruction count.

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, TRAP=10.

Opcode classification:
- An opcode is legal only if opcode[1:0]=11 and opcode[3:2]=00.
- opcode[6:4] selects the class: 011 = R-type, 001 = I-ALU, 000 = load, 010 = store, 110 = branch.
- Anything else goes to TRAP.

Per-state outputs. Any output not listed in a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite equal `rdy`, where `rdy` = `mem_ready` if MEM_WAIT=1, else 1. Holds until `rdy`, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (computes the branch target). Next state by class:
  - load/store → MEMADR
  - R-type → EXEC_R
  - I-ALU → EXEC_I
  - branch → BRANCH
  - illegal → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Load → MEMRD; store → MEMWR.
- MEMRD: IorD=1, MemRead=1. Holds until `rdy`, then MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, then FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until `rdy`, then FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=11, then ALUWB.
- ALUWB: RegWrite=1, MemToReg=0, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=`zero`, then FETCH.
- TRAP: all enables 0 and `illegal`=1. Absorbing: only reset leaves it.

`opcode` is sampled only in DECODE and MEMADR. It must be stable from DECODE until the instruction retires, which is guaranteed because IRWrite=0 outside FETCH.

Retired-instruction counter:
- `retired` increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
- Wraps modulo 2^CNT_W.
- Never increments in TRAP.

## Timing
- Reset (`reset`=0, asynchronous): `state`=FETCH, `retired`=0, `illegal`=0. All 1-bit enables, ALUSrcA, ALUSrcB and ALUOp are forced to 0 while reset is low.
- First FETCH outputs appear in the cycle after reset is released.
- Reset asserted mid-instruction aborts immediately. No RegWrite, MemWrite or PCWrite may pulse after reset is asserted.
- Outputs are combinational from registered `state` (Moore). The exceptions are PCWrite/IRWrite gated by `rdy` in FETCH and PCWrite gated by `zero` in BRANCH.
- Cycles per instruction with zero memory wait:

| Class  | Cycles |
|--------|--------|
| load   | 5      |
| store  | 4      |
| R-type | 4      |
| I-ALU  | 4      |
| branch | 3      |

- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held constant while waiting.
- `mem_ready` is a don't-care outside FETCH, MEMRD and MEMWR.
- MEM_WAIT=0: a `mem_ready` held low has no effect.
- Wrap example: with CNT_W=4, the 16th retirement returns `retired` from 15 to 0.

## Test plan
- Reset, then opcode 0110011 (R-type) with `mem_ready`=1: state sequence 0,1,6,8,0. RegWrite=1 only in state 8. ALUOp=10 in state 6. `retired`=1.
- Load 0000011 with `mem_ready` low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 held through MEMRD. MemToReg=1 and RegWrite=1 in state 4.
- Branch 1100011 with `zero`=1, then again with `zero`=0: PCWrite=1 and PCWrite=0 respectively in state 9. PCSrc=1 in both. `retired` advances by 2.
- Opcode 1111111: DECODE goes to TRAP (10). `illegal`=1 and all enables stay 0 for 20 cycles, even with legal opcodes applied afterwards. Reset clears to FETCH with `illegal`=0.
- Store 0100011 with reset pulsed low in MEMWR: MemWrite drops to 0 asynchronously, state=0, `retired`=0.
- CNT_W=4: retire 17 I-ALU (0010011) instructions → `retired`=1. Each instruction's sequence is 0,1,7,8 with ALUOp=11 in state 7.
